// File: rtl/riscv_mem_arb_pkg.sv
// Shared types and constants for the IF/DM single-port SRAM arbiter.
package riscv_mem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    RS_NONE,
    RS_IF,
    RS_DM
  } resp_sel_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating IF starvation counter: clear has priority over increment.
module mem_arb_starve_ctr
  import riscv_mem_arb_pkg::*;
#(
  parameter int W     = STARVE_W,
  parameter int LIMIT = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q >= LIM);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates core IF and DM ports onto one SP_SRAM: DM priority with IF starvation override.
// Optional MEM_ARB_STATS_EN adds IF stall and DM access counters.
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int AWIDTH       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              IF_REQ,
  input  logic [11:0]       IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [31:0]       IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [11:0]       DM_ADDR,
  input  logic [3:0]        DM_BE,
  input  logic [31:0]       DM_WDATA,
  output logic              DM_GNT,
  output logic              DM_RVALID,
  output logic [31:0]       DM_RDATA,
  output logic              SRAM_CSN,
  output logic              SRAM_WEN,
  output logic [3:0]        SRAM_BE,
  output logic [AWIDTH-1:0] SRAM_ADDR,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DOUT
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       ARB_IF_STALLS,
  output logic [31:0]       ARB_DM_ACCESSES
`endif
);

  logic      if_at_limit;
  logic      if_stall;
  resp_sel_t resp_sel_q;
  resp_sel_t resp_sel_d;
  logic      unused_addr_lsbs;

  assign unused_addr_lsbs = ^{IF_ADDR[1:0], DM_ADDR[1:0]};

  mem_arb_starve_ctr #(
    .W     (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .clr      (!IF_REQ || IF_GNT),
    .inc      (if_stall),
    .at_limit (if_at_limit)
  );

  // Grants are gated by RSTn so nothing reaches the SRAM while in reset.
  always_comb begin
    DM_GNT     = RSTn && DM_REQ && !(IF_REQ && if_at_limit);
    IF_GNT     = RSTn && IF_REQ && !DM_GNT;
    if_stall   = IF_REQ && !IF_GNT;
    SRAM_CSN   = 1'b1;
    SRAM_WEN   = 1'b1;
    SRAM_BE    = 4'b0000;
    SRAM_ADDR  = '0;
    SRAM_DI    = 32'd0;
    resp_sel_d = RS_NONE;
    if (DM_GNT) begin
      SRAM_CSN  = 1'b0;
      SRAM_ADDR = DM_ADDR[AWIDTH+1:2];
      if (DM_WE) begin
        SRAM_WEN = 1'b0;
        SRAM_BE  = DM_BE;
        SRAM_DI  = DM_WDATA;
      end else begin
        resp_sel_d = RS_DM;
      end
    end else if (IF_GNT) begin
      SRAM_CSN   = 1'b0;
      SRAM_ADDR  = IF_ADDR[AWIDTH+1:2];
      resp_sel_d = RS_IF;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      resp_sel_q <= RS_NONE;
    end else begin
      resp_sel_q <= resp_sel_d;
    end
  end

  assign IF_RVALID = RSTn && (resp_sel_q == RS_IF);
  assign DM_RVALID = RSTn && (resp_sel_q == RS_DM);
  assign IF_RDATA  = SRAM_DOUT;
  assign DM_RDATA  = SRAM_DOUT;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_stalls_q;
  logic [31:0] if_stalls_d;
  logic [31:0] dm_acc_q;
  logic [31:0] dm_acc_d;

  always_comb begin
    if_stalls_d = if_stalls_q;
    dm_acc_d    = dm_acc_q;
    if (if_stall) begin
      if_stalls_d = if_stalls_q + 32'd1;
    end
    if (DM_GNT) begin
      dm_acc_d = dm_acc_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      if_stalls_q <= 32'd0;
      dm_acc_q    <= 32'd0;
    end else begin
      if_stalls_q <= if_stalls_d;
      dm_acc_q    <= dm_acc_d;
    end
  end

  assign ARB_IF_STALLS   = if_stalls_q;
  assign ARB_DM_ACCESSES = dm_acc_q;
`endif

  // Requesters must hold REQ until granted; at most one grant per cycle.
  a_if_hold: assert property (@(posedge CLK) disable iff (!RSTn) (IF_REQ && !IF_GNT) |=> IF_REQ);
  a_dm_hold: assert property (@(posedge CLK) disable iff (!RSTn) (DM_REQ && !DM_GNT) |=> DM_REQ);
  a_one_gnt: assert property (@(posedge CLK) !(IF_GNT && DM_GNT));

endmodule
